rr_select_scheduler: RTL



---
 rtl/sched_pkg.sv | 32 +++
 rtl/rr_select_scheduler_if.sv | 37 +++
 rtl/sel_onehot_dec.sv | 46 ++++
 rtl/rr_select_scheduler.sv | 94 +++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin select scheduler.
// Provides the FSM state type, the requester/index/counter widths, and the
// rotating-priority winner search used by the scheduler top.
package sched_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // First set bit of req, searching from ptr upward with wrap-around.
    // Rotating req right by ptr turns the search into a plain lowest-bit scan;
    // the modulo-8 wrap of the result falls out of the IDX_W-bit add.
    function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] off;
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/rr_select_scheduler_if.sv
// Requester-side bus of the select scheduler.
//   req       : request vector, bit i = requester i wants the select
//   done      : release strobe from the current owner
//   gnt       : one-hot grant (zero when no grant is active)
//   gnt_idx   : index of the current / last owner
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse after a forced release
// master = requester agents, slave = scheduler.
interface rr_select_scheduler_if;
    import sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/sel_onehot_dec.sv
// Registered-input 3-to-8 select decode.
// Registers the next owner index and valid flag, then decodes the registered
// index to a one-hot line, forced to zero while valid is low. Because the
// one-hot is a pure function of these two flops it always matches idx_o.
//   clk, rst   : clock, synchronous active-high reset
//   idx_i      : next-cycle owner index
//   valid_i    : next-cycle grant active
//   idx_o      : registered owner index
//   valid_o    : registered grant active
//   onehot_o   : decode of idx_o gated by valid_o
module sel_onehot_dec
    import sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             valid_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic [N_REQ-1:0] onehot_o
);

    logic [IDX_W-1:0] idx_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_i;
            valid_q <= valid_i;
        end
    end

    always_comb begin
        onehot_o = '0;
        if (valid_q) begin
            onehot_o[idx_q] = 1'b1;
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rr_select_scheduler.sv
// Round-robin owner of a shared 3-bit select / 8-line one-hot decode.
// In idle the first requester at or after the priority pointer wins; the grant
// is held until done, owner withdrawal or MAX_HOLD cycles, after which the
// pointer moves past the owner. One idle cycle always separates two owners.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester bus (req/done in, gnt/gnt_idx/gnt_valid/timeout out)
// Parameter MAX_HOLD: longest grant in cycles, legal range 1..255.
module rr_select_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_select_scheduler_if.slave bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_d;
    logic             valid_q;

    logic normal_rel;
    logic hold_exp;

    // A voluntary release takes precedence, so timeout only flags a pure expiry.
    assign normal_rel = bus.done | ~bus.req[idx_q];
    assign hold_exp   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        idx_d      = idx_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d    = StGrant;
                    idx_d      = next_rr(bus.req, ptr_q);
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                if (normal_rel || hold_exp) begin
                    state_d    = StIdle;
                    ptr_d      = idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    timeout_d  = ~normal_rel;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        valid_d = (state_d == StGrant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Owner index and valid live in the decoder so gnt can never disagree with gnt_idx.
    sel_onehot_dec u_dec (
        .clk      (clk),
        .rst      (rst),
        .idx_i    (idx_d),
        .valid_i  (valid_d),
        .idx_o    (idx_q),
        .valid_o  (valid_q),
        .onehot_o (bus.gnt)
    );

    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule
